// File: rtl/fx2_adc_fifo_writer.sv
// FX2LP slave-FIFO capture path: samples the ADC bus at a programmable rate,
// buffers the samples and streams them into the selected IN endpoint.
module fx2_adc_fifo_writer #(
  parameter int         DEPTH_LOG2 = 4,
  parameter int         PKT_BYTES  = 512,
  parameter logic [1:0] EP_ADDR    = 2'b10
) (
  input  logic        IFCLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [25:0] RATE,
  input  logic [7:0]  ADC_DATA,
  output logic [7:0]  FD_OUT,
  output logic        FD_OE,
  output logic        SLWRN,
  output logic        SLOEN,
  output logic [1:0]  FIFOADR,
  input  logic        FULLN,
  output logic        PKTENDN,
  output logic        OVERFLOW,
  output logic        BUSY
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PKT_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_PKTEND
  } state_e;

  state_e                state_q, state_d;
  logic [25:0]           rate_cnt_q, rate_cnt_d;
  logic [25:0]           rate_max;
  logic [7:0]            sample_q;
  logic                  push_pend_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q, fill;
  logic [PKT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  fifo_empty, fifo_full;
  logic                  pop, push, strobe;

  // RATE of 0 behaves exactly like 1 (a sample every cycle).
  assign rate_max   = (RATE == 26'd0) ? 26'd0 : RATE - 26'd1;
  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == (DEPTH_LOG2 + 1)'(DEPTH));

  assign pop    = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !fifo_empty && FULLN;
  assign push   = push_pend_q && (!fifo_full || pop);
  assign strobe = (state_q == S_RUN) && ENABLE && (rate_cnt_q == 26'd0);

  always_comb begin
    state_d    = state_q;
    rate_cnt_d = '0;
    pkt_cnt_d  = pkt_cnt_q;
    ovf_d      = ovf_q;

    if (pop) begin
      pkt_cnt_d = (pkt_cnt_q == PKT_W'(PKT_BYTES - 1)) ? '0 : pkt_cnt_q + 1'b1;
    end
    if (push_pend_q && !push) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          state_d = S_RUN;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        rate_cnt_d = (rate_cnt_q >= rate_max) ? '0 : rate_cnt_q + 26'd1;
        if (!ENABLE) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A partial packet is committed only once the FX2 can accept the strobe.
        if (fifo_empty) begin
          if (pkt_cnt_q == '0) begin
            state_d = S_IDLE;
          end else if (FULLN) begin
            state_d = S_PKTEND;
          end
        end
      end
      S_PKTEND: begin
        state_d   = S_IDLE;
        pkt_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge IFCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      rate_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      sample_q    <= '0;
      push_pend_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      rate_cnt_q  <= rate_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      ovf_q       <= ovf_d;
      push_pend_q <= strobe;
      if (strobe) begin
        sample_q <= ADC_DATA;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge IFCLK) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= sample_q;
    end
  end

  // Show-ahead head; forced to zero when empty so the bus is defined after reset.
  assign FD_OUT   = fifo_empty ? 8'd0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign FD_OE    = (state_q != S_IDLE);
  assign SLWRN    = ~pop;
  assign PKTENDN  = ~(state_q == S_PKTEND);
  assign OVERFLOW = ovf_q;
  assign BUSY     = (state_q != S_IDLE);
  assign SLOEN    = 1'b1;
  assign FIFOADR  = EP_ADDR;

endmodule

// File: doc/fx2_adc_fifo_writer.md
Name: fx2_adc_fifo_writer

Overview:
- Capture direction of the FX2LP slave-FIFO link: samples the 8-bit ADC bus at a programmable rate and buffers samples in an internal FIFO.
- Writes buffered bytes into the FX2LP IN endpoint FIFO using SLWRN.
- On stop, commits any short packet with a PKTENDN pulse.
- Sits between the ADDA pins and the FD/flag pins in the top level. RATE and ENABLE come from Qsys PIO registers.

Parameters:
- DEPTH_LOG2, 4, internal FIFO depth = 2^DEPTH_LOG2 bytes.
- PKT_BYTES, 512, FX2 endpoint packet size in bytes. Must be a power of two, at most 1024.
- EP_ADDR, 2'b10, value driven on FIFOADR (EP6).

Ports:
- IFCLK  in  1  48 MHz interface clock. All logic is on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  capture run request, synchronous to IFCLK.
- RATE  in  26  sample period in IFCLK cycles. 0 is treated as 1.
- ADC_DATA  in  8  ADC sample bus.
- FD_OUT  out  8  data to the FX2 FD bus.
- FD_OE  out  1  FD tristate enable (top level drives FD = FD_OE ? FD_OUT : z).
- SLWRN  out  1  FX2 write strobe, active low.
- SLOEN  out  1  constant 1.
- FIFOADR  out  2  constant EP_ADDR.
- FULLN  in  1  FX2 full flag for the selected endpoint, active low (0 = full).
- PKTENDN  out  1  FX2 packet-end strobe, active low.
- OVERFLOW  out  1  sticky flag: a sample was dropped.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: SLWRN=1, PKTENDN=1, FD_OE=0, FD_OUT=0, OVERFLOW=0, BUSY=0. FIFO empty; rate counter, packet byte counter and state all cleared. Reset mid-operation discards buffered data and does not emit PKTENDN.
- Rate counter: runs only in RUN. Wraps to 0 when it equals max(RATE,1)-1. The sample strobe is asserted when count==0.
- On a sample strobe, ADC_DATA is registered and pushed with 1-cycle latency.
- A push is accepted if the FIFO is not full or a pop occurs in the same cycle. Otherwise the sample is dropped and OVERFLOW is set.
- OVERFLOW clears only on reset or on an IDLE->RUN transition.
- Pop/write is combinational: SLWRN = ~(state in {RUN,DRAIN} & FIFO not empty & FULLN).
  - FD_OUT = FIFO head (show-ahead). FD_OE=1 in RUN, DRAIN and PKTEND.
  - A pop occurs on every rising edge where SLWRN==0.
- Packet byte counter: increments modulo PKT_BYTES on each pop.
- States:
  - IDLE: ENABLE=1 -> RUN. The rate counter is cleared on entry to RUN, so the first strobe comes in the first RUN cycle.
  - RUN: ENABLE=0 -> DRAIN. Sampling stops; no further pushes, including any strobe in that cycle.
  - DRAIN: FIFO empty and byte counter==0 -> IDLE. FIFO empty and byte counter!=0 and FULLN=1 -> PKTEND. ENABLE is ignored.
  - PKTEND: PKTENDN=0 for exactly one cycle, SLWRN held at 1. Byte counter cleared. Next state IDLE.
- PKTENDN and SLWRN are never low in the same cycle.
- FULLN=0 stalls writes indefinitely. Sampling continues in RUN, and overflow occurs once the FIFO fills.
- A full packet (counter wraps to 0) relies on FX2 auto-commit; no PKTENDN is issued.

Test Plan:
- Reset, then ENABLE=1, RATE=4, FULLN=1, ADC_DATA ramping 0,1,2,… each cycle -> pushes 0,4,8,…. SLWRN low one cycle after each push with FD_OUT equal to the pushed value. OVERFLOW=0.
- RATE=0 vs RATE=1, FULLN=1 -> identical behaviour: one sample every cycle, SLWRN continuously low after the first cycle.
- RATE=1 with FULLN=0 held 40 cycles -> exactly 16 bytes buffered (DEPTH_LOG2=4), OVERFLOW=1 from the 17th strobe. Release FULLN -> the 16 buffered bytes are written in order.
- Capture 100 bytes, then ENABLE=0 -> FIFO drains, then a single PKTENDN low pulse with SLWRN=1. BUSY falls one cycle later.
- Capture exactly 512 bytes, then ENABLE=0 -> no PKTENDN pulse; IDLE is reached after the drain.
- Assert RESET_N=0 in DRAIN with 5 bytes buffered -> all outputs return to reset values immediately; no PKTENDN; after release the FIFO is empty.
